// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, scheduler state type and the 5-bit LFSR step
// for the lfsr_sched random source.
package lfsr_pkg;
    localparam int LFSR_W      = 5;
    localparam int LFSR_PERIOD = 31;
    localparam logic [LFSR_W-1:0] LFSR_SAFE_SEED = 5'h01;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} sched_state_t;

    // x^5 + x^3 + 1, right-shifting Fibonacci form
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[0] ^ q[2], q[4:1]};
    endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: 5-bit maximal-length LFSR state register with seed load.
// A load wins over a step when both are requested in the same cycle.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SAFE_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);
    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    r_q <= SEED;
        else if (load) r_q <= load_val;
        else if (step) r_q <= lfsr_next(r_q);
    end

    assign q = r_q;
endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: IDLE/LOAD/RUN configurator and round-robin scheduler handing out
// one LFSR value per grant to NUM_REQ requesters.
module lfsr_sched
    import lfsr_pkg::*;
#(
    parameter int                NUM_REQ      = 2,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 5'h01
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_en,
    input  logic               cfg_load,
    input  logic [LFSR_W-1:0]  cfg_seed,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [LFSR_W-1:0]  rnd_data,
    output logic               wrap,
    output logic               running
);
    localparam int PW = $clog2(NUM_REQ);
    localparam logic [LFSR_W-1:0] CORE_SEED = (SEED_DEFAULT == '0) ? LFSR_SAFE_SEED : SEED_DEFAULT;
    localparam logic [4:0] CNT_LAST = 5'(LFSR_PERIOD - 1);

    sched_state_t      r_state;
    logic [PW-1:0]     r_ptr;
    logic [4:0]        r_cnt;
    logic [LFSR_W-1:0] r_seed;
    logic [NUM_REQ-1:0] r_gnt;
    logic              r_valid;
    logic [LFSR_W-1:0] r_data;
    logic              r_wrap;

    logic [LFSR_W-1:0]  w_q;
    logic [NUM_REQ-1:0] w_rot;
    logic [PW-1:0]      w_win;
    logic               w_grant;
    logic               w_last;

    assign w_grant = (r_state == RUN) && cfg_en && !cfg_load && |req;
    assign w_last  = r_cnt == CNT_LAST;

    // rotate so bit 0 is the requester just after the last winner
    assign w_rot = NUM_REQ'({req, req} >> (r_ptr + PW'(1)));

    always_comb begin
        w_win = r_ptr;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (w_rot[j]) w_win = PW'((int'(r_ptr) + 1 + j) % NUM_REQ);
    end

    lfsr_core #(.SEED(CORE_SEED)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (r_state == LOAD),
        .load_val ((r_seed == '0) ? LFSR_SAFE_SEED : r_seed),
        .step     (w_grant),
        .q        (w_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_seed  <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_gnt   <= w_grant ? NUM_REQ'(1) << w_win : '0;
            r_valid <= w_grant;
            r_wrap  <= w_grant && w_last;
            if (w_grant) begin
                r_data <= w_q;
                r_ptr  <= w_win;
                r_cnt  <= w_last ? '0 : r_cnt + 5'd1;
            end
            if (r_state == LOAD) r_cnt <= '0;
            if (r_state != LOAD && cfg_load) r_seed <= cfg_seed;
            r_state <= (r_state != LOAD && cfg_load) ? LOAD : cfg_en ? RUN : IDLE;
        end
    end

    assign gnt       = r_gnt;
    assign rnd_valid = r_valid;
    assign rnd_data  = r_data;
    assign wrap      = r_wrap;
    assign running   = r_state == RUN;
endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: directed scenarios plus randomized traffic, every cycle
// compared against a behavioural model of the scheduler.
module tb_lfsr_sched;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_en, cfg_load;
    logic [4:0]   cfg_seed;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         rnd_valid, wrap, running;
    logic [4:0]   rnd_data;

    int n_cmp = 0, n_bad = 0;
    bit chk_on = 0;
    int cyc = 0;
    int got_d[$], got_g[$], got_w[$], got_c[$];

    lfsr_sched #(.NUM_REQ(N), .SEED_DEFAULT(5'h01)) dut (
        .clk(clk), .reset(reset), .cfg_en(cfg_en), .cfg_load(cfg_load),
        .cfg_seed(cfg_seed), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .wrap(wrap), .running(running)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int step(input int q);
        return ((q >> 1) | (((q ^ (q >> 2)) & 1) << 4)) & 31;
    endfunction

    // behavioural model: mode 0=idle 1=loading 2=running; m_cnt counts values issued 1..31
    int m_mode = 0, m_lfsr = 1, m_ptr = N - 1, m_cnt = 0, m_seed = 0;
    int e_gnt = 0, e_v = 0, e_d = 0, e_w = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_lfsr = 1; m_ptr = N - 1; m_cnt = 0; m_seed = 0;
            e_gnt = 0; e_v = 0; e_d = 0; e_w = 0;
        end else begin
            int win;
            win = -1;
            e_gnt = 0; e_v = 0; e_w = 0;
            if (m_mode == 2 && cfg_en && !cfg_load && req != 0) begin
                for (int k = 1; k <= N; k++)
                    if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                e_gnt = 1 << win; e_v = 1; e_d = m_lfsr;
                m_lfsr = step(m_lfsr); m_ptr = win; m_cnt++;
                if (m_cnt == 31) begin e_w = 1; m_cnt = 0; end
            end
            if (m_mode == 1) begin
                m_lfsr = (m_seed == 0) ? 1 : m_seed; m_cnt = 0;
                m_mode = cfg_en ? 2 : 0;
            end else if (cfg_load) begin
                m_seed = cfg_seed; m_mode = 1;
            end else m_mode = cfg_en ? 2 : 0;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (chk_on) begin
            check("gnt", gnt, e_gnt);
            check("rnd_valid", rnd_valid, e_v);
            check("rnd_data", rnd_data, e_d);
            check("wrap", wrap, e_w);
            check("running", running, m_mode == 2);
        end
        if (rnd_valid) begin
            got_d.push_back(rnd_data); got_g.push_back(gnt);
            got_w.push_back(wrap); got_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_d.delete(); got_g.delete(); got_w.delete(); got_c.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; cfg_en = 0; cfg_load = 0; cfg_seed = 0; req = 0;
        repeat (2) @(negedge clk);
        clear_log();
        reset = 1;
    endtask

    task automatic wait_grants(input int n);
        int b;
        b = 0;
        while (got_d.size() < n && b < 300) begin @(negedge clk); b++; end
        if (got_d.size() < n) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_grants: got %0d grants expected %0d", got_d.size(), n);
        end
    endtask

    logic [4:0] seq[6] = '{5'h01, 5'h10, 5'h08, 5'h04, 5'h12, 5'h09};

    initial begin
        int nw;
        reset = 1; cfg_en = 0; cfg_load = 0; cfg_seed = 0; req = 0;
        #3 reset = 0;
        #1 chk_on = 1;
        check("reset_gnt", gnt, 0);
        check("reset_data", rnd_data, 0);
        check("reset_running", running, 0);

        // single requester stream
        do_reset();
        cfg_en = 1; req = 2'b01;
        wait_grants(6); req = 0;
        for (int i = 0; i < 6; i++) begin
            check("seq_data", got_d[i], seq[i]);
            check("seq_gnt", got_g[i], 1);
        end

        // two requesters, enable drop and resume
        do_reset();
        cfg_en = 1; req = 2'b11;
        wait_grants(4); cfg_en = 0;
        repeat (3) @(negedge clk);
        check("hold_gnt", gnt, 0);
        check("hold_running", running, 0);
        check("hold_count", got_d.size(), 4);
        cfg_en = 1;
        wait_grants(6); req = 0;
        for (int i = 0; i < 6; i++) begin
            check("rr_data", got_d[i], seq[i]);
            check("rr_gnt", got_g[i], (i % 2 == 0) ? 1 : 2);
        end

        // seed load mid-stream, then a zero seed
        do_reset();
        cfg_en = 1; req = 2'b01;
        wait_grants(3);
        cfg_load = 1; cfg_seed = 5'h14;
        @(negedge clk) cfg_load = 0;
        wait_grants(5); req = 0;
        check("load_d0", got_d[3], 5'h14);
        check("load_d1", got_d[4], 5'h1A);
        check("load_gap", got_c[3] - got_c[2], 3);
        @(negedge clk) begin cfg_load = 1; cfg_seed = 5'h00; end
        @(negedge clk) begin cfg_load = 0; req = 2'b01; end
        wait_grants(6); req = 0;
        check("zero_seed", got_d[5], 5'h01);

        // full period and wrap pulses
        do_reset();
        cfg_en = 1; req = 2'b01;
        wait_grants(62); req = 0;
        check("wrap31", got_w[30], 1);
        check("wrap62", got_w[61], 1);
        nw = 0;
        foreach (got_w[i]) nw += got_w[i];
        check("wrap_count", nw, 2);
        check("period_repeat", got_d[31], 5'h01);

        // async reset between edges
        do_reset();
        cfg_en = 1; req = 2'b11;
        wait_grants(3);
        @(posedge clk); #2;
        check("pre_rst_valid", rnd_valid, 1);
        reset = 0;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_valid", rnd_valid, 0);
        check("arst_wrap", wrap, 0);
        check("arst_running", running, 0);
        @(negedge clk) begin clear_log(); reset = 1; end
        wait_grants(1); req = 0;
        check("post_rst_data", got_d[0], 5'h01);
        check("post_rst_gnt", got_g[0], 1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cfg_en   = ($urandom_range(0, 7) != 0);
            cfg_load = ($urandom_range(0, 15) == 0);
            cfg_seed = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom);
            req      = N'($urandom);
            if ($urandom_range(0, 199) == 0) begin #2 reset = 0; #2 reset = 1; end
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lfsr_sched.md
Name: lfsr_sched

Overview:
Scheduler and configurator for a shared 5-bit maximal-length LFSR random source. Holds the LFSR state, handles seed load and enable, and round-robin arbitrates NUM_REQ requesters. Each grant delivers one LFSR value and advances the LFSR by one step. Sits between the LFSR datapath and the consumer blocks that need pseudo-random values.

Parameters:
NUM_REQ, 2, number of requesters (legal 2..8)
SEED_DEFAULT, 5'h01, LFSR value on reset; must be non-zero

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
cfg_en  input  1  level; 1 = grants allowed (RUN), 0 = hold (IDLE)
cfg_load  input  1  single-cycle pulse; load cfg_seed into the LFSR
cfg_seed  input  5  seed value; 0 is replaced by 5'h01
req  input  NUM_REQ  level request per requester
gnt  output  NUM_REQ  registered one-hot grant, one cycle per value
rnd_valid  output  1  registered; equals |gnt
rnd_data  output  5  registered LFSR value issued with gnt
wrap  output  1  one-cycle pulse with the 31st value issued since last load/reset
running  output  1  1 when FSM is in RUN

Behaviour:
- LFSR step (x^5+x^3+1, right shift): next = {q[0]^q[2], q[4:1]}. Period 31; state 0 is unreachable.
- Reset (reset low, async) sets:
  - gnt=0, rnd_valid=0, rnd_data=0, wrap=0.
  - LFSR=SEED_DEFAULT, step counter=0.
  - RR pointer=NUM_REQ-1, so req[0] has first priority.
  - FSM=IDLE.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: no grants. cfg_load -> LOAD. cfg_en=1 -> RUN.
  - LOAD: single cycle. LFSR<=(cfg_seed_latched==0 ? 5'h01 : cfg_seed_latched), counter<=0, no grant. Then -> RUN if cfg_en, else -> IDLE.
  - RUN: cfg_load -> LOAD (load takes priority; no grant that cycle). cfg_en=0 -> IDLE, no grant that cycle.
- cfg_seed is captured on the cfg_load cycle.
- Grant (RUN, cfg_en=1, cfg_load=0, |req=1). Winner = first set req scanning from ptr+1 modulo NUM_REQ. At that edge:
  - gnt<=onehot(winner), rnd_data<=LFSR, rnd_valid<=1.
  - LFSR<=next(LFSR), ptr<=winner, counter increments.
- Latency: req sampled high in cycle k -> gnt/rnd_data valid in cycle k+1.
- At most one grant per cycle.
- req is a level. A requester holding req receives one value per cycle it wins. A requester wanting exactly one value drops req in the cycle gnt is seen.
- gnt/rnd_valid are 0 in any cycle with no grant. rnd_data holds its last issued value.
- Counter: 5-bit. When a grant makes the 31st value since load/reset, wrap=1 alongside that gnt and counter<=0.
- cfg_en falling mid-stream: requests sampled with cfg_en=0 get no grant. LFSR, pointer and counter are held.
- Reset mid-operation: immediate return to reset values. Any in-flight gnt is dropped.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=5, LFSR_PERIOD=31.
  - Constant LFSR_SAFE_SEED=5'h01.
  - Enum sched_state_t {IDLE, LOAD, RUN}.
  - Function lfsr_next(q) implementing the step above.
- One sub-module, lfsr_core:
  - Holds the 5-bit state register.
  - Ports: clk, reset, load, load_val, step, q.
  - Priority: load over step.
- lfsr_sched contains the FSM, RR arbiter, counter and output registers.

Test Plan:
- Release reset, cfg_en=1, req=01 held 6 cycles -> gnt[0] each cycle from cycle after first sample. rnd_data sequence 0x01,0x10,0x08,0x04,0x12,0x09.
- req=11 held 4 cycles after reset -> gnt 01,10,01,10. rnd_data 0x01,0x10,0x08,0x04.
- cfg_load with cfg_seed=0 -> LFSR becomes 0x01. cfg_load with cfg_seed=0x14 while req=01 -> no grant that cycle, one LOAD cycle, next rnd_data=0x14 then 0x1A.
- req=01 held 62 cycles from reset -> wrap pulses on the 31st and 62nd grants. The 32nd value equals 0x01 again.
- Drop cfg_en mid-stream with req=11 -> gnt=0 from the next cycle. Re-enable -> sequence and RR order resume where they stopped.
- Assert reset low mid-stream (asynchronously, between edges) -> gnt, rnd_valid and wrap go 0 immediately. After release, first value is 0x01 to req[0].
